ifmap_row_streamer: RTL and testbench

//  Clocked ifmap store-and-stream block: input-facing end of the ifmap load protocol
//  (timestep / addr / data writes, then load_done). Captures two binary 25x25 spike

---
 rtl/snn_pkg.sv | 36 +++
 rtl/ifmap_bitmap_store.sv | 55 +++++
 rtl/ifmap_row_streamer.sv | 118 +++++++++++
 tb/tb_ifmap_row_streamer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared sizes, packet layout and FSM encoding
// for the ifmap load-and-stream path.
package snn_pkg;

  localparam int DEPTH_I     = 25;
  localparam int DEPTH_F     = 5;
  localparam int ADDR_WIDTH  = 10;
  localparam int PACK_WIDTH  = 64;
  localparam int OUT_ROWS    = DEPTH_I - DEPTH_F + 1;
  localparam int NUM_PACKETS = OUT_ROWS * DEPTH_F;
  localparam int NUM_CELLS   = DEPTH_I * DEPTH_I;

  localparam int MAP1_LSB = 0;
  localparam int MAP2_LSB = 25;
  localparam int ROW_LSB  = 50;
  localparam int OROW_LSB = 55;
  localparam int PAD_LSB  = 60;

  typedef logic [DEPTH_I-1:0] ifmap_row_t;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [PACK_WIDTH-1:0] pack_packet(
    input ifmap_row_t m1,
    input ifmap_row_t m2,
    input logic [4:0] r,
    input logic [4:0] o
  );
    return {4'b0, o, r, m2, m1};
  endfunction

endpackage

// File: rtl/ifmap_bitmap_store.sv
// Two 25x25 spike bitmaps with a bit write port and a
// row read port that already reflects a same-cycle write.
module ifmap_bitmap_store
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            wr_ts,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_data,
  input  logic [4:0]            rd_row,
  output ifmap_row_t            rd_row1,
  output ifmap_row_t            rd_row2
);

  ifmap_row_t map1 [DEPTH_I];
  ifmap_row_t map2 [DEPTH_I];

  logic       wr_ok;
  logic       ts_ok;
  logic       addr_ok;
  logic [4:0] wr_row;
  logic [4:0] wr_col;

  assign ts_ok   = (wr_ts == 2'd1) || (wr_ts == 2'd2);
  assign addr_ok = wr_addr < ADDR_WIDTH'(NUM_CELLS);
  assign wr_ok   = wr_en && ts_ok && addr_ok;
  assign wr_row  = 5'(wr_addr / ADDR_WIDTH'(DEPTH_I));
  assign wr_col  = 5'(wr_addr % ADDR_WIDTH'(DEPTH_I));

  // Bit writes; reset clears both maps
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_I; i++) begin
        map1[i] <= '0;
        map2[i] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_ts == 2'd1) map1[wr_row][wr_col] <= wr_data;
      else               map2[wr_row][wr_col] <= wr_data;
    end
  end

  // Row read with forwarding of a write landing this edge
  always_comb begin
    rd_row1 = map1[rd_row];
    rd_row2 = map2[rd_row];
    if (wr_ok && (wr_row == rd_row)) begin
      if (wr_ts == 2'd1) rd_row1[wr_col] = wr_data;
      else               rd_row2[wr_col] = wr_data;
    end
  end

endmodule

// File: rtl/ifmap_row_streamer.sv
// Captures two ifmap timesteps, then streams 105 row
// packets in 5x5 convolution-window order.
module ifmap_row_streamer
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_ts,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  state_t     state;
  logic [4:0] o_cnt;
  logic [2:0] k_cnt;
  logic [4:0] o_nxt;
  logic [2:0] k_nxt;
  logic [4:0] r_nxt;
  logic       wr_hs;
  logic       ld_hs;
  logic       out_hs;
  logic       last_pkt;
  ifmap_row_t row1;
  ifmap_row_t row2;

  assign in_ready = (state == ST_LOAD) && !reset;
  assign ld_ready = (state == ST_LOAD) && !reset;
  assign wr_hs    = in_valid && in_ready;
  assign ld_hs    = ld_valid && ld_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_pkt = (o_cnt == 5'(OUT_ROWS - 1))
                 && (k_cnt == 3'(DEPTH_F - 1));

  // Window position of the packet to load next
  always_comb begin
    o_nxt = '0;
    k_nxt = '0;
    if (state == ST_SEND) begin
      if (k_cnt == 3'(DEPTH_F - 1)) begin
        k_nxt = '0;
        o_nxt = o_cnt + 5'd1;
      end else begin
        k_nxt = k_cnt + 3'd1;
        o_nxt = o_cnt;
      end
    end
    r_nxt = o_nxt + 5'(k_nxt);
  end

  ifmap_bitmap_store u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_hs),
    .wr_ts   (in_ts),
    .wr_addr (in_addr),
    .wr_data (in_data),
    .rd_row  (r_nxt),
    .rd_row1 (row1),
    .rd_row2 (row2)
  );

  // FSM, window counters and packet register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_LOAD;
      o_cnt      <= '0;
      k_cnt      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          frame_done <= 1'b0;
          if (ld_hs) begin
            state     <= ST_SEND;
            out_valid <= 1'b1;
            out_data  <= pack_packet(row1, row2,
                                     r_nxt, o_nxt);
          end
        end
        ST_SEND: begin
          if (out_hs) begin
            if (last_pkt) begin
              state      <= ST_DONE;
              out_valid  <= 1'b0;
              out_data   <= '0;
              frame_done <= 1'b1;
              o_cnt      <= '0;
              k_cnt      <= '0;
            end else begin
              o_cnt    <= o_nxt;
              k_cnt    <= k_nxt;
              out_data <= pack_packet(row1, row2,
                                      r_nxt, o_nxt);
            end
          end
        end
        ST_DONE: begin
          frame_done <= 1'b0;
          state      <= ST_LOAD;
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_row_streamer.sv
// Directed bench for ifmap_row_streamer: load, stream,
// stall, invalid writes, mid-frame reset, pending load_done.
module tb_ifmap_row_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ts;
  logic [9:0]  in_addr;
  logic        in_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  logic [24:0] m1 [25];
  logic [24:0] m2 [25];
  logic [63:0] pkt_first;
  logic [63:0] pkt_last;
  int          fd_count;

  always #5 clk = ~clk;

  ifmap_row_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ts      (in_ts),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 25; i++) begin
      m1[i] = '0;
      m2[i] = '0;
    end
  endtask

  function automatic logic [63:0] exp_pkt(input int p);
    int o;
    int r;
    logic [4:0] o5;
    logic [4:0] r5;
    o  = p / 5;
    r  = o + (p % 5);
    o5 = 5'(o);
    r5 = 5'(r);
    return {4'b0, o5, r5, m2[r], m1[r]};
  endfunction

  task automatic model_wr(input logic [1:0] ts,
                          input int addr,
                          input logic d);
    if (addr < 625) begin
      if (ts == 2'd1) m1[addr/25][addr%25] = d;
      if (ts == 2'd2) m2[addr/25][addr%25] = d;
    end
  endtask

  task automatic wr(input logic [1:0] ts,
                    input int addr,
                    input logic d);
    in_valid = 1'b1;
    in_ts    = ts;
    in_addr  = 10'(addr);
    in_data  = d;
    tick();
    in_valid = 1'b0;
    model_wr(ts, addr, d);
  endtask

  task automatic start_frame();
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    chk("enter_send_valid", 64'(out_valid), 64'd1);
    chk("enter_send_in_rdy", 64'(in_ready), 64'd0);
  endtask

  // Stream one frame; optional stall, abort and
  // pending load_done raised at given packet indices.
  task automatic run_frame(input int stall_at,
                           input int abort_at,
                           input int ld_at);
    fd_count  = 0;
    out_ready = 1'b1;
    for (int p = 0; p < 105; p++) begin
      if (p == abort_at) begin
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_data", out_data, 64'd0);
        chk("abort_fd", 64'(frame_done), 64'd0);
        reset = 1'b0;
        #1;
        chk("abort_in_rdy", 64'(in_ready), 64'd1);
        chk("abort_ld_rdy", 64'(ld_ready), 64'd1);
        clear_model();
        out_ready = 1'b1;
        return;
      end
      if (p == ld_at) ld_valid = 1'b1;
      chk($sformatf("valid_p%0d", p),
          64'(out_valid), 64'd1);
      chk($sformatf("data_p%0d", p),
          out_data, exp_pkt(p));
      chk($sformatf("ld_rdy_p%0d", p),
          64'(ld_ready), 64'd0);
      if (frame_done) fd_count++;
      if (p == 0)   pkt_first = out_data;
      if (p == 104) pkt_last  = out_data;
      if (p == stall_at) begin
        out_ready = 1'b0;
        repeat (10) begin
          tick();
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_data", out_data, exp_pkt(p));
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_fd", 64'(frame_done), 64'd1);
    chk("done_ld_rdy", 64'(ld_ready), 64'd0);
    if (frame_done) fd_count++;
    tick();
    if (frame_done) fd_count++;
    chk("fd_pulses", 64'(fd_count), 64'd1);
    chk("back_load_in_rdy", 64'(in_ready), 64'd1);
    chk("back_load_ld_rdy", 64'(ld_ready), 64'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_ts     = 2'd0;
    in_addr   = '0;
    in_data   = 1'b0;
    ld_valid  = 1'b0;
    out_ready = 1'b0;
    clear_model();

    // Reset state
    tick();
    chk("rst_in_rdy", 64'(in_ready), 64'd0);
    chk("rst_ld_rdy", 64'(ld_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_fd", 64'(frame_done), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_rdy", 64'(in_ready), 64'd1);
    chk("post_rst_ld_rdy", 64'(ld_ready), 64'd1);

    // 1: identity map1, zero map2
    for (int a = 0; a < 625; a++) begin
      wr(2'd1, a, (a / 25) == (a % 25));
      wr(2'd2, a, 1'b0);
    end
    start_frame();
    run_frame(-1, -1, -1);
    chk("t1_p0_map1", 64'(pkt_first[24:0]), 64'h1);
    chk("t1_p0_ro", 64'(pkt_first[59:50]), 64'd0);
    chk("t1_p104_r", 64'(pkt_last[54:50]), 64'd24);
    chk("t1_p104_o", 64'(pkt_last[59:55]), 64'd20);
    chk("t1_p104_b24", 64'(pkt_last[24]), 64'd1);

    // 2: backpressure at p=7, retained maps
    start_frame();
    run_frame(7, -1, -1);

    // 3: dropped writes leave cleared maps untouched
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    wr(2'd0, 0, 1'b1);
    wr(2'd3, 5, 1'b1);
    wr(2'd1, 625, 1'b1);
    wr(2'd2, 1023, 1'b1);
    wr(2'd3, 1023, 1'b1);
    wr(2'd0, 624, 1'b1);
    start_frame();
    run_frame(-1, -1, -1);
    chk("t3_p0_maps", 64'(pkt_first[49:0]), 64'd0);
    chk("t3_p104_maps", 64'(pkt_last[49:0]), 64'd0);

    // 4: final write in the same cycle as load_done
    in_valid = 1'b1;
    in_ts    = 2'd2;
    in_addr  = 10'd624;
    in_data  = 1'b1;
    ld_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ld_valid = 1'b0;
    model_wr(2'd2, 624, 1'b1);
    chk("t4_valid", 64'(out_valid), 64'd1);
    run_frame(-1, -1, -1);
    chk("t4_p104_b49", 64'(pkt_last[49]), 64'd1);

    // 5: reset at p=50, then all-ones reload
    start_frame();
    run_frame(-1, 50, -1);
    for (int a = 0; a < 625; a++) begin
      wr(2'd1, a, 1'b1);
      wr(2'd2, a, 1'b1);
    end
    start_frame();
    run_frame(-1, -1, -1);
    chk("t5_p0_ones", 64'(pkt_first[49:0]),
        64'h3_FFFF_FFFF_FFFF);

    // 6: load_done raised in SEND waits for LOAD
    start_frame();
    run_frame(-1, -1, 3);
    tick();
    ld_valid = 1'b0;
    chk("t6_relaunch", 64'(out_valid), 64'd1);
    run_frame(-1, -1, -1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
